// File: rtl/jk_bank_arbiter.sv
// Round-robin req/ack arbiter sequencing one requester's J/K command onto a shared JK bank.
// Build option: define JK_ARB_FIXED_PRI_EN to pin the pointer at 0 (lowest index always wins).
module jk_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WIDTH-1:0]    cmd_j,
  input  logic [NREQ*WIDTH-1:0]    cmd_k,
  output logic [NREQ-1:0]          grant,
  output logic                     ack,
  output logic                     busy,
  output logic [WIDTH-1:0]         q
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_apply = 2'd1,
    st_wait  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [IW-1:0]    ptr_r, ptr_s, win_r, win_s, pick_s, next_ptr_s;
  logic [NREQ-1:0]  grant_r, grant_s;
  logic             ack_r, ack_s, busy_r;
  logic [WIDTH-1:0] q_r, q_s, j_sel_s, k_sel_s;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
    int s;
    s = (int'(base) + off) % NREQ;
    return s[IW-1:0];
  endfunction

  // JK characteristic per bit: 00 hold, 01 clear, 10 set, 11 toggle
  function automatic logic [WIDTH-1:0] jk_update(input logic [WIDTH-1:0] cur,
                                                 input logic [WIDTH-1:0] j,
                                                 input logic [WIDTH-1:0] k);
    return (j & ~cur) | (~k & cur);
  endfunction

  // Winner search: lowest offset from the pointer wins, so scan from the far end down
  always_comb begin
    pick_s = ptr_r;
    for (int off = NREQ - 1; off >= 0; off--) begin
      pick_s = req[wrap_add(ptr_r, off)] ? wrap_add(ptr_r, off) : pick_s;
    end
  end

  // Select the granted requester's J/K slice
  always_comb begin
    j_sel_s = {WIDTH{1'b0}};
    k_sel_s = {WIDTH{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      j_sel_s = j_sel_s | (cmd_j[i*WIDTH +: WIDTH] & {WIDTH{win_r == IW'(i)}});
      k_sel_s = k_sel_s | (cmd_k[i*WIDTH +: WIDTH] & {WIDTH{win_r == IW'(i)}});
    end
  end

  // Pointer after a transaction closes
  always_comb begin
`ifdef JK_ARB_FIXED_PRI_EN
    next_ptr_s = {IW{1'b0}};
`else
    next_ptr_s = wrap_add(win_r, 1);
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    win_s   = win_r;
    grant_s = grant_r;
    ack_s   = ack_r;
    q_s     = q_r;
    case (state_r)
      st_idle: begin
        if (|req) begin
          win_s   = pick_s;
          grant_s = {{(NREQ-1){1'b0}}, 1'b1} << pick_s;
          state_s = st_apply;
        end else begin
          state_s = st_idle;
        end
      end
      st_apply: begin
        if (req[win_r]) begin
          q_s     = jk_update(q_r, j_sel_s, k_sel_s);
          ack_s   = 1'b1;
          state_s = st_wait;
        end else begin
          grant_s = {NREQ{1'b0}};
          ptr_s   = next_ptr_s;
          state_s = st_idle;
        end
      end
      st_wait: begin
        if (!req[win_r]) begin
          ack_s   = 1'b0;
          grant_s = {NREQ{1'b0}};
          ptr_s   = next_ptr_s;
          state_s = st_idle;
        end else begin
          state_s = st_wait;
        end
      end
      default: begin
        state_s = st_idle;
        grant_s = {NREQ{1'b0}};
        ack_s   = 1'b0;
      end
    endcase
  end

  // State and output registers, updated on the falling edge
  always_ff @(negedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= st_idle;
      ptr_r   <= {IW{1'b0}};
      win_r   <= {IW{1'b0}};
      grant_r <= {NREQ{1'b0}};
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      q_r     <= {WIDTH{1'b0}};
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      win_r   <= win_s;
      grant_r <= grant_s;
      ack_r   <= ack_s;
      busy_r  <= (state_s != st_idle);
      q_r     <= q_s;
    end
  end

  assign grant = grant_r;
  assign ack   = ack_r;
  assign busy  = busy_r;
  assign q     = q_r;

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Bench for jk_bank_arbiter: directed vector table, async-reset sequence, then random
// requesters checked against a transaction-level reference model.
module tb_jk_bank_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [31:0] cmd_j, cmd_k;
  logic [3:0]  grant;
  logic        ack, busy;
  logic [7:0]  q;

  int vectors     = 0;
  int miscompares = 0;

  jk_bank_arbiter #(.NREQ(4), .WIDTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .cmd_j(cmd_j), .cmd_k(cmd_k),
    .grant(grant), .ack(ack), .busy(busy), .q(q)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  req;
    logic [31:0] j;
    logic [31:0] k;
    logic [3:0]  grant;
    logic        ack;
    logic        busy;
    logic [7:0]  q;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic [31:0] j, input logic [31:0] k,
                     input logic [3:0] g, input logic a, input logic b, input logic [7:0] qq);
    vec_t v;
    v.req = r; v.j = j; v.k = k; v.grant = g; v.ack = a; v.busy = b; v.q = qq;
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] eg, input logic ea,
                       input logic eb, input logic [7:0] eq);
    vectors++;
    if ({grant, ack, busy, q} !== {eg, ea, eb, eq}) begin
      miscompares++;
      $display("FAIL %s: got grant=%b ack=%b busy=%b q=%h, expected grant=%b ack=%b busy=%b q=%h",
               name, grant, ack, busy, q, eg, ea, eb, eq);
    end
  endtask

  // one falling (active) edge, then sample on the following rising edge
  task automatic step();
    @(negedge clk);
    @(posedge clk);
  endtask

  // ---------------- reference model (transaction level) ----------------
  int         m_owner;   // -1 when nobody holds the bank
  bit         m_done;    // command of current owner already applied
  int         m_ptr;
  logic [7:0] m_q;

  function automatic logic [7:0] jk_ref(input logic [7:0] cur, input logic [7:0] j,
                                        input logic [7:0] k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) begin
      case ({j[b], k[b]})
        2'b00:   r[b] = cur[b];
        2'b01:   r[b] = 1'b0;
        2'b10:   r[b] = 1'b1;
        default: r[b] = ~cur[b];
      endcase
    end
    return r;
  endfunction

  function automatic int after(input int w);
`ifdef JK_ARB_FIXED_PRI_EN
    return 0;
`else
    return (w + 1) % 4;
`endif
  endfunction

  task automatic model_reset();
    m_owner = -1; m_done = 1'b0; m_ptr = 0; m_q = 8'h00;
  endtask

  task automatic model_step(input logic [3:0] r, input logic [31:0] j, input logic [31:0] k);
    if (m_owner < 0) begin
      for (int n = 0; n < 4; n++) begin
        if (r[(m_ptr + n) % 4]) begin
          m_owner = (m_ptr + n) % 4;
          m_done  = 1'b0;
          break;
        end
      end
    end else if (!m_done) begin
      if (r[m_owner]) begin
        m_q    = jk_ref(m_q, j[m_owner*8 +: 8], k[m_owner*8 +: 8]);
        m_done = 1'b1;
      end else begin
        m_ptr   = after(m_owner);
        m_owner = -1;
      end
    end else if (!r[m_owner]) begin
      m_ptr   = after(m_owner);
      m_owner = -1;
      m_done  = 1'b0;
    end
  endtask

  function automatic logic [3:0] m_grant();
    logic [3:0] one;
    one = 4'b0001;
    return (m_owner >= 0) ? (one << m_owner) : 4'b0000;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    reset_n = 1'b0; req = 4'h0; cmd_j = 32'h0; cmd_k = 32'h0;
    model_reset();
    @(posedge clk);
    check("reset_state", 4'b0000, 1'b0, 1'b0, 8'h00);
    step();
    reset_n = 1'b1;

    // single requester, toggle, hold
    add(4'b0010, 32'h0000F000, 32'h00000F00, 4'b0010, 1'b0, 1'b1, 8'h00);
    add(4'b0010, 32'h0000F000, 32'h00000F00, 4'b0010, 1'b1, 1'b1, 8'hF0);
    add(4'b0010, 32'h0000F000, 32'h00000F00, 4'b0010, 1'b1, 1'b1, 8'hF0);
    add(4'b0000, 32'h0000F000, 32'h00000F00, 4'b0000, 1'b0, 1'b0, 8'hF0);
    add(4'b0100, 32'h00CC0000, 32'h00CC0000, 4'b0100, 1'b0, 1'b1, 8'hF0);
    add(4'b0100, 32'h00CC0000, 32'h00CC0000, 4'b0100, 1'b1, 1'b1, 8'h3C);
    add(4'b0000, 32'h00CC0000, 32'h00CC0000, 4'b0000, 1'b0, 1'b0, 8'h3C);
    add(4'b1000, 32'h00000000, 32'h00000000, 4'b1000, 1'b0, 1'b1, 8'h3C);
    add(4'b1000, 32'h00000000, 32'h00000000, 4'b1000, 1'b1, 1'b1, 8'h3C);
    add(4'b0000, 32'h00000000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h3C);
`ifndef JK_ARB_FIXED_PRI_EN
    // round robin 0,1,2,3,0 with all requests held
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0001, 1'b0, 1'b1, 8'h3C);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0001, 1'b1, 1'b1, 8'h3D);
    add(4'b1110, 32'h08000201, 32'h08040000, 4'b0000, 1'b0, 1'b0, 8'h3D);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0010, 1'b0, 1'b1, 8'h3D);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0010, 1'b1, 1'b1, 8'h3F);
    add(4'b1101, 32'h08000201, 32'h08040000, 4'b0000, 1'b0, 1'b0, 8'h3F);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0100, 1'b0, 1'b1, 8'h3F);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0100, 1'b1, 1'b1, 8'h3B);
    add(4'b1011, 32'h08000201, 32'h08040000, 4'b0000, 1'b0, 1'b0, 8'h3B);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b1000, 1'b0, 1'b1, 8'h3B);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b1000, 1'b1, 1'b1, 8'h33);
    add(4'b0111, 32'h08000201, 32'h08040000, 4'b0000, 1'b0, 1'b0, 8'h33);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0001, 1'b0, 1'b1, 8'h33);
    add(4'b1111, 32'h08000201, 32'h08040000, 4'b0001, 1'b1, 1'b1, 8'h33);
    add(4'b1110, 32'h08000201, 32'h08040000, 4'b0000, 1'b0, 1'b0, 8'h33);
    // withdrawal: requester 2 granted then drops before the apply edge
    add(4'b0100, 32'h00FF0000, 32'h00000000, 4'b0100, 1'b0, 1'b1, 8'h33);
    add(4'b0000, 32'h00FF0000, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'h33);
    // wrap-around: pointer at 3 picks 3, then 0
    add(4'b1001, 32'h000000FF, 32'hFF000000, 4'b1000, 1'b0, 1'b1, 8'h33);
    add(4'b1001, 32'h000000FF, 32'hFF000000, 4'b1000, 1'b1, 1'b1, 8'h00);
    add(4'b0001, 32'h000000FF, 32'hFF000000, 4'b0000, 1'b0, 1'b0, 8'h00);
    add(4'b1001, 32'h000000FF, 32'hFF000000, 4'b0001, 1'b0, 1'b1, 8'h00);
    add(4'b1001, 32'h000000FF, 32'hFF000000, 4'b0001, 1'b1, 1'b1, 8'hFF);
    add(4'b1000, 32'h000000FF, 32'hFF000000, 4'b0000, 1'b0, 1'b0, 8'hFF);
    add(4'b0000, 32'h000000FF, 32'hFF000000, 4'b0000, 1'b0, 1'b0, 8'hFF);
`else
    // fixed priority: requester 0 wins every arbitration it enters
    add(4'b1111, 32'h000000FF, 32'h00000000, 4'b0001, 1'b0, 1'b1, 8'h3C);
    add(4'b1111, 32'h000000FF, 32'h00000000, 4'b0001, 1'b1, 1'b1, 8'hFF);
    add(4'b1110, 32'h000000FF, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'hFF);
    add(4'b1111, 32'h000000FF, 32'h00000000, 4'b0001, 1'b0, 1'b1, 8'hFF);
    add(4'b1111, 32'h000000FF, 32'h00000000, 4'b0001, 1'b1, 1'b1, 8'hFF);
    add(4'b1110, 32'h000000FF, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'hFF);
    add(4'b0000, 32'h000000FF, 32'h00000000, 4'b0000, 1'b0, 1'b0, 8'hFF);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req; cmd_j = tbl[i].j; cmd_k = tbl[i].k;
      step();
      check($sformatf("table_row_%0d", i), tbl[i].grant, tbl[i].ack, tbl[i].busy, tbl[i].q);
    end

    // asynchronous reset while parked in WAIT with q=A5
    req = 4'b0010; cmd_j = 32'h0000A500; cmd_k = 32'h00005A00;
    step();
    check("rst_seq_grant", 4'b0010, 1'b0, 1'b1, 8'hFF);
    step();
    check("rst_seq_apply", 4'b0010, 1'b1, 1'b1, 8'hA5);
    step();
    check("rst_seq_wait", 4'b0010, 1'b1, 1'b1, 8'hA5);
    reset_n = 1'b0;
    #1;
    check("async_reset", 4'b0000, 1'b0, 1'b0, 8'h00);
    req = 4'b0000;
    step();
    reset_n = 1'b1;
    model_reset();
    step();
    check("post_reset_idle", 4'b0000, 1'b0, 1'b0, 8'h00);

    // randomized requesters obeying the handshake
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i]) begin
          cmd_j[i*8 +: 8] = 8'($urandom);
          cmd_k[i*8 +: 8] = 8'($urandom);
          if ($urandom_range(0, 3) == 0) req[i] = 1'b1;
        end else if (m_owner == i && m_done) begin
          if ($urandom_range(0, 2) != 0) req[i] = 1'b0;
        end else if (m_owner == i) begin
          if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
        end else begin
          if ($urandom_range(0, 31) == 0) req[i] = 1'b0;
        end
      end
      model_step(req, cmd_j, cmd_k);
      step();
      check($sformatf("random_cycle_%0d", c), m_grant(), m_done, (m_owner >= 0), m_q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
